inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch/issue stage directly upstream of the cpu control FSM. Holds a small
//  writable instruction store and a PC, and presents one 16-bit instruction on d_inst.
//  Pulses run to start each instruction, then waits for the cpu's done before advancing.
//  Stops on a HALT-format instruction, the last address, or a stop request.
// PARAMETERS
//  ADDR_W  5    instruction store address width; DEPTH = 2**ADDR_W words
//  INST_W  16   instruction width; must equal the cpu d_inst width
//  WD_MAX  64   watchdog limit in cycles spent in WAIT (used only with INST_FETCH_WD_EN)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  reset_n     in   1       synchronous, active-low reset
//  start       in   1       begin execution from address 0 (honoured in IDLE/HALT only)
//  stop        in   1       request halt after the current instruction completes
//  done        in   1       completion strobe from the cpu
//  ld_en       in   1       instruction store write enable (IDLE/HALT only)
//  ld_addr     in   ADDR_W  write address
//  ld_data     in   INST_W  write data
//  run         out  1       one-cycle issue pulse to the cpu
//  d_inst      out  INST_W  instruction register; stable from issue through done
//  pc          out  ADDR_W  address of the current instruction
//  busy        out  1       high in FETCH/ISSUE/WAIT
//  halted      out  1       high in HALT
//  retired     out  8       count of completed instructions; saturates at 255
//  wd_err      out  1       watchdog fired (tied 0 without INST_FETCH_WD_EN)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE; run=0, d_inst=0, pc=0, busy=0, halted=0,
//   retired=0, wd_err=0, stop_pend=0. Store contents are not cleared. Reset mid-WAIT
//   aborts with no further run pulse.
//  FSM: IDLE -start-> FETCH -> ISSUE -> WAIT -done-> FETCH | HALT; HALT -start-> FETCH.
//  On a start, pc<=0, retired<=0, stop_pend<=0 and wd_err<=0.
//  FETCH (1 cycle): synchronous read, d_inst<=mem[pc].
//  ISSUE: if d_inst[1:0]==2'b11 (HALT format), go to HALT with no run pulse; retired and
//   pc are unchanged. Otherwise drive run=1 for exactly this cycle, then go to WAIT.
//  Latency: start sampled at cycle N -> run high at cycle N+2.
//  WAIT: hold d_inst and pc. On done: retired++ (saturating). Then go to HALT if
//   stop_pend, stop or pc==DEPTH-1 (pc is not wrapped); otherwise pc<=pc+1 and go to FETCH.
//  stop in FETCH/ISSUE/WAIT sets stop_pend; stop and done in the same cycle halts after
//   that instruction. stop in IDLE/HALT is ignored.
//  done outside WAIT is ignored. start while busy is ignored.
//  ld_en while busy is ignored (no write). Writes complete in 1 cycle.
//  A write and a start in the same cycle: the write lands first, and the fetch sees the
//   new data.
// CONFIGURATION
//  INST_FETCH_WD_EN defined: a counter clears on WAIT entry and increments each WAIT cycle.
//   If it reaches WD_MAX without done: wd_err<=1, go to HALT, retired unchanged.
//   wd_err stays set until reset or start.
//  Not defined: no counter; wd_err is tied 0; WAIT can last indefinitely.
// STRUCTURE
//  inst_fetch_pkg: state enum {IDLE, FETCH, ISSUE, WAIT, HALT}; FMT_HALT=2'b11;
//   INST_W default; fmt field slice constants.
//  Sub-module inst_store: DEPTH x INST_W, one write port, one synchronous read port.
//  Top holds the FSM, PC, stop_pend, retired counter and the optional watchdog.
// TESTING
//  1. Load 3 non-halt words then 16'h0003 at addr 3; start; answer each run with done
//     2 cycles later -> 3 run pulses, retired=3, halted=1, pc=3.
//  2. start at cycle 10 -> run high at cycle 12, d_inst=mem[0]; d_inst stays unchanged
//     until done.
//  3. stop asserted while in WAIT of instruction 0, done 4 cycles later -> HALT, retired=1,
//     no second run.
//  4. Fill all 32 words non-halt -> after 32nd done, HALT with pc=31; pc never wraps to 0.
//  5. Drop reset_n mid-WAIT, and pulse ld_en and done while busy -> all outputs return to
//     reset values; the store is unmodified by the busy-time write.
//  6. INST_FETCH_WD_EN, WD_MAX=8, done withheld -> wd_err=1 and halted=1 after 8 WAIT
//     cycles. Without the macro, the block stays in WAIT.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch/issue stage.
package inst_fetch_pkg;

    localparam int ADDR_W_DFLT = 5;
    localparam int INST_W_DFLT = 16;

    // Format field occupies the two LSBs of every instruction word.
    localparam int FMT_LSB = 0;
    localparam int FMT_MSB = 1;
    localparam logic [1:0] FMT_HALT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HALT  = 3'd4
    } state_e;

endpackage

// File: rtl/inst_store.sv
// Instruction store: DEPTH x INST_W words, one write port, one synchronous
// read port. The read register doubles as the instruction register, so it
// only updates on rd_en and holds otherwise. The array itself is not reset.
module inst_store
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int INST_W = INST_W_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [INST_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rd_data_d;
    logic [INST_W-1:0] rd_data_q;

    // Array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds unless a read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch/issue stage feeding the cpu control FSM.
// Optional watchdog on the WAIT state is built when INST_FETCH_WD_EN is defined.
//
// state | meaning
// IDLE  | out of reset, waiting for start; store writable
// FETCH | synchronous read of mem[pc] into the instruction register
// ISSUE | HALT-format word -> HALT, otherwise one-cycle run pulse
// WAIT  | instruction held until the cpu answers with done
// HALT  | stopped; store writable, start restarts from address 0
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int INST_W = INST_W_DFLT,
    parameter int WD_MAX = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              done,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [INST_W-1:0] ld_data,
    output logic              run,
    output logic [INST_W-1:0] d_inst,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        retired,
    output logic              wd_err
);

    // pc saturates at the last word instead of wrapping.
    localparam logic [ADDR_W-1:0] PC_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              stop_pend_q, stop_pend_d;
    logic [7:0]        retired_q, retired_d;
    logic              store_wr_en;
    logic              store_rd_en;

`ifdef INST_FETCH_WD_EN
    localparam int WD_W = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_MAX - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q, wd_err_d;
`endif

    inst_store #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (store_wr_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (store_rd_en),
        .rd_addr (pc_q),
        .rd_data (d_inst)
    );

    // Next-state, PC, retire counter, stop request and issue pulse.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stop_pend_d = stop_pend_q;
        retired_d   = retired_q;
        run         = 1'b0;
        store_rd_en = 1'b0;
        store_wr_en = ld_en && ((state_q == IDLE) || (state_q == HALT));
`ifdef INST_FETCH_WD_EN
        wd_cnt_d    = wd_cnt_q;
        wd_err_d    = wd_err_q;
`endif

        if (stop && ((state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT))) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d     = FETCH;
                    pc_d        = '0;
                    retired_d   = '0;
                    stop_pend_d = 1'b0;
`ifdef INST_FETCH_WD_EN
                    wd_err_d    = 1'b0;
`endif
                end
            end
            FETCH: begin
                store_rd_en = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (d_inst[FMT_MSB:FMT_LSB] == FMT_HALT) begin
                    state_d = HALT;
                end else begin
                    run     = 1'b1;
                    state_d = WAIT;
`ifdef INST_FETCH_WD_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (done) begin
                    if (retired_q != 8'hFF) begin
                        retired_d = retired_q + 8'd1;
                    end
                    if (stop_pend_q || stop || (pc_q == PC_LAST)) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = FETCH;
                    end
                end
`ifdef INST_FETCH_WD_EN
                else if (wd_cnt_q == WD_LAST) begin
                    wd_err_d = 1'b1;
                    state_d  = HALT;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            stop_pend_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stop_pend_q <= stop_pend_d;
            retired_q   <= retired_d;
        end
    end

`ifdef INST_FETCH_WD_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_err = 1'b0;
`endif

    assign pc      = pc_q;
    assign busy    = (state_q == FETCH) || (state_q == ISSUE) || (state_q == WAIT);
    assign halted  = (state_q == HALT);
    assign retired = retired_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch. Expected run sequence, final pc
// and retire count come from walking a copy of the store contents.
module tb_inst_fetch;

    localparam int ADDR_W = 5;
    localparam int INST_W = 16;
    localparam int DEPTH  = 32;
    localparam int WD_MAX = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              stop;
    logic              done;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [INST_W-1:0] ld_data;
    logic              run;
    logic [INST_W-1:0] d_inst;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic [7:0]        retired;
    logic              wd_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [INST_W-1:0] ref_mem [DEPTH];

    inst_fetch #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .WD_MAX (WD_MAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .done    (done),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .run     (run),
        .d_inst  (d_inst),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .retired (retired),
        .wd_err  (wd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [INST_W-1:0] rand_word(input bit allow_halt);
        logic [INST_W-1:0] w;
        w = INST_W'($urandom);
        if (allow_halt && ($urandom_range(0, 7) == 0)) begin
            w[1:0] = 2'b11;
        end else if (w[1:0] == 2'b11) begin
            w[1:0] = 2'b01;
        end
        return w;
    endfunction

    task automatic load(input int a, input logic [INST_W-1:0] d);
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(a);
        ld_data = d;
        step();
        ld_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic fill(input bit allow_halt);
        for (int a = 0; a < DEPTH; a++) begin
            load(a, rand_word(allow_halt));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_run"},     32'(run),     32'd0);
        check_eq({tag, "_d_inst"},  32'(d_inst),  32'd0);
        check_eq({tag, "_pc"},      32'(pc),      32'd0);
        check_eq({tag, "_busy"},    32'(busy),    32'd0);
        check_eq({tag, "_halted"},  32'(halted),  32'd0);
        check_eq({tag, "_retired"}, 32'(retired), 32'd0);
        check_eq({tag, "_wd_err"},  32'(wd_err),  32'd0);
    endtask

    // Start a program and play the cpu. stop_idx: run index to stop on (-1 none);
    // stop_lead > 0 raises stop on the first WAIT cycle and done stop_lead cycles
    // later, stop_lead == 0 raises stop together with done.
    task automatic run_prog(input string tag, input int stop_idx, input int stop_lead,
                            input int dly_lo, input int dly_hi,
                            input bit ld_with_start, input logic [INST_W-1:0] ld_word);
        int exp_runs[$];
        int exp_pc;
        int i;
        int k;
        int cyc;
        int dly;
        logic [INST_W-1:0] held;
        logic [ADDR_W-1:0] held_pc;

        if (ld_with_start) ref_mem[0] = ld_word;
        i = 0;
        exp_pc = 0;
        forever begin
            if (ref_mem[i][1:0] == 2'b11) begin
                exp_pc = i;
                break;
            end
            exp_runs.push_back(i);
            if ((exp_runs.size() - 1 == stop_idx) || (i == DEPTH - 1)) begin
                exp_pc = i;
                break;
            end
            i++;
        end

        start = 1'b1;
        if (ld_with_start) begin
            ld_en   = 1'b1;
            ld_addr = '0;
            ld_data = ld_word;
        end
        step();
        start = 1'b0;
        ld_en = 1'b0;
        cyc = 1;
        k = 0;
        while (!halted && cyc < 2000) begin
            if (run) begin
                check_eq({tag, "_run_pc"}, 32'(pc),
                         (k < exp_runs.size()) ? 32'(exp_runs[k]) : 32'hFFFF_FFFF);
                check_eq({tag, "_run_inst"}, 32'(d_inst),
                         (k < exp_runs.size()) ? 32'(ref_mem[exp_runs[k]]) : 32'hFFFF_FFFF);
                check_eq({tag, "_run_busy"}, 32'(busy), 32'd1);
                if (k == 0) check_eq({tag, "_start_to_run"}, 32'(cyc), 32'd2);
                held    = d_inst;
                held_pc = pc;
                step();
                cyc++;
                check_eq({tag, "_run_width"}, 32'(run), 32'd0);
                if ((k == stop_idx) && (stop_lead > 0)) begin
                    dly  = stop_lead;
                    stop = 1'b1;
                end else begin
                    dly = $urandom_range(dly_lo, dly_hi);
                end
                for (int j = 0; j < dly; j++) begin
                    step();
                    cyc++;
                    stop = 1'b0;
                    check_eq({tag, "_hold_inst"}, 32'(d_inst), 32'(held));
                    check_eq({tag, "_hold_pc"}, 32'(pc), 32'(held_pc));
                end
                done = 1'b1;
                if ((k == stop_idx) && (stop_lead == 0)) stop = 1'b1;
                step();
                cyc++;
                done = 1'b0;
                stop = 1'b0;
                k++;
            end else begin
                step();
                cyc++;
            end
        end
        check_eq({tag, "_halt_seen"}, 32'(halted), 32'd1);
        check_eq({tag, "_run_count"}, 32'(k), 32'(exp_runs.size()));
        check_eq({tag, "_retired"}, 32'(retired),
                 (exp_runs.size() > 255) ? 32'd255 : 32'(exp_runs.size()));
        check_eq({tag, "_final_pc"}, 32'(pc), 32'(exp_pc));
        check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
        check_eq({tag, "_wd_err"}, 32'(wd_err), 32'd0);
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!run && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_run_arrives"}, 32'(run), 32'd1);
    endtask

    initial begin
        logic [INST_W-1:0] w;
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        done    = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        step();
        step();
        reset_n = 1'b1;
        check_reset_values("reset");
        step();
        check_reset_values("idle");

        // three ordinary words then a HALT-format word, done two cycles after run
        for (int a = 0; a < 3; a++) load(a, rand_word(1'b0));
        load(3, 16'h0003);
        run_prog("t1", -1, 0, 2, 2, 1'b0, '0);

        // stop ignored while halted
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("halt_stop_ignored", 32'(halted), 32'd1);

        // stop during WAIT of instruction 0, done 4 cycles later
        fill(1'b0);
        run_prog("t3", 0, 4, 0, 0, 1'b0, '0);

        // full store of ordinary words: halts at the last address
        run_prog("t4", -1, 0, 0, 1, 1'b0, '0);

        // write and start in the same cycle: fetch sees the new word
        run_prog("wr_start", 2, 0, 0, 2, 1'b1, rand_word(1'b0));

        // randomized programs
        for (int t = 0; t < 6; t++) begin
            fill(1'b1);
            run_prog("rnd", ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1,
                     int'($urandom_range(0, 3)), 0, 3, 1'b0, '0);
        end

        // busy-time write is dropped; reset mid-WAIT aborts
        fill(1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_run("t5");
        step();
        w = ~ref_mem[1];
        if (w[1:0] == 2'b11) w[1:0] = 2'b00;
        ld_en   = 1'b1;
        ld_addr = 5'd1;
        ld_data = w;
        step();
        ld_en   = 1'b0;
        reset_n = 1'b0;
        done    = 1'b1;
        step();
        reset_n = 1'b1;
        done    = 1'b0;
        check_reset_values("t5_reset");
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("t5_no_run", 32'(run), 32'd0);
        end
        run_prog("t5_after", -1, 0, 0, 1, 1'b0, '0);

        // done withheld in WAIT
        load(0, rand_word(1'b0));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_run("t6");
`ifdef INST_FETCH_WD_EN
        for (int n = 0; n < WD_MAX; n++) step();
        check_eq("t6_not_yet", 32'(halted), 32'd0);
        step();
        check_eq("t6_halted", 32'(halted), 32'd1);
        check_eq("t6_wd_err", 32'(wd_err), 32'd1);
        check_eq("t6_retired", 32'(retired), 32'd0);
        run_prog("t6_restart", 1, 0, 0, 2, 1'b0, '0);
`else
        for (int n = 0; n < 100; n++) step();
        check_eq("t6_busy", 32'(busy), 32'd1);
        check_eq("t6_halted", 32'(halted), 32'd0);
        check_eq("t6_wd_err", 32'(wd_err), 32'd0);
        check_eq("t6_retired", 32'(retired), 32'd0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_reset_values("t6_reset");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
